// File: rtl/alu_control_sequencer_pkg.sv
// Shared types for the ALU control sequencer: FSM states, opcode map,
// ALU flag bit positions and the instruction word layout.
package alu_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXECUTE,
    ST_WRITEBACK,
    ST_HALTED
  } state_e;

  localparam logic [5:0] OP_BRA  = 6'b100000;
  localparam logic [5:0] OP_BEQ  = 6'b100001;
  localparam logic [5:0] OP_BNE  = 6'b100010;
  localparam logic [5:0] OP_BCS  = 6'b100011;
  localparam logic [5:0] OP_BMI  = 6'b100100;
  localparam logic [5:0] OP_BVS  = 6'b100101;
  localparam logic [5:0] OP_HALT = 6'b111111;

  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_O = 0;

  typedef struct packed {
    logic [5:0] op;
    logic       s;
    logic [2:0] dst;
    logic [2:0] src1;
    logic [2:0] src2;
  } instr_t;

  function automatic logic is_alu_op(input logic [5:0] op);
    return !op[5];
  endfunction

  function automatic logic is_branch_op(input logic [5:0] op);
    return op inside {OP_BRA, OP_BEQ, OP_BNE, OP_BCS, OP_BMI, OP_BVS};
  endfunction

endpackage

// File: rtl/alu_control_sequencer_if.sv
// Instruction handshake plus ALU/register-file control bus; the sequencer
// is the master, the datapath (or a bench) is the slave.
interface alu_control_sequencer_if #(
  parameter int INSTR_W = 16,
  parameter int PC_W    = 16
);
  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] instr_data;
  logic [3:0]         FlagsIn;
  logic [4:0]         FunSel;
  logic               WF;
  logic [2:0]         rf_rsel_a;
  logic [2:0]         rf_rsel_b;
  logic               rf_we;
  logic [2:0]         rf_wsel;
  logic               pc_load;
  logic [PC_W-1:0]    pc_offset;
  logic               halted;
  logic               illegal_op;

  modport master (
    input  instr_valid, instr_data, FlagsIn,
    output instr_ready, FunSel, WF, rf_rsel_a, rf_rsel_b, rf_we, rf_wsel,
           pc_load, pc_offset, halted, illegal_op
  );

  modport slave (
    output instr_valid, instr_data, FlagsIn,
    input  instr_ready, FunSel, WF, rf_rsel_a, rf_rsel_b, rf_we, rf_wsel,
           pc_load, pc_offset, halted, illegal_op
  );
endinterface

// File: rtl/alu_control_sequencer_branch_cond_eval.sv
// Resolves a branch opcode against the ALU flags; non-branch opcodes
// always evaluate as not taken.
module branch_cond_eval
  import alu_ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [3:0] flags,
  output logic       taken
);

  always_comb begin
    // NOTE: default assignment first, so no path through the case leaves
    // taken unassigned and infers a latch.
    taken = 1'b0;
    case (op)
      OP_BRA:  taken = 1'b1;
      OP_BEQ:  taken = flags[FLAG_Z];
      OP_BNE:  taken = !flags[FLAG_Z];
      OP_BCS:  taken = flags[FLAG_C];
      OP_BMI:  taken = flags[FLAG_N];
      OP_BVS:  taken = flags[FLAG_O];
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_control_sequencer.sv
// Issuing side of the ALU FunSel/WF/Flags interface: accepts instructions,
// then walks DECODE/EXECUTE/WRITEBACK driving ALU, register-file and PC strobes.
module alu_control_sequencer
  import alu_ctrl_pkg::*;
#(
  parameter int INSTR_W  = 16,
  parameter int OFFSET_W = 9,
  parameter int PC_W     = 16
) (
  input  logic                    Clock,
  input  logic                    Reset,
  alu_control_sequencer_if.master bus
);

  state_e             state_q, state_d;
  logic [INSTR_W-1:0] ir_q;
  instr_t             ir;
  logic               accept;
  logic               taken;
  logic               op_alu, op_branch, op_halt;

  logic               instr_ready_c, wf_c, rf_we_c, pc_load_c, halted_c, illegal_c;
  logic [4:0]         funsel_c;
  logic [2:0]         rsel_a_c, rsel_b_c, wsel_c;
  logic [PC_W-1:0]    pc_offset_c;
  logic [PC_W-1:0]    offset_sext;

  assign ir          = instr_t'(ir_q);
  assign op_alu      = is_alu_op(ir.op);
  assign op_branch   = is_branch_op(ir.op);
  assign op_halt     = (ir.op == OP_HALT);
  assign accept      = bus.instr_valid && instr_ready_c;
  assign offset_sext = {{(PC_W-OFFSET_W){ir_q[OFFSET_W-1]}}, ir_q[OFFSET_W-1:0]};

  branch_cond_eval u_branch_cond_eval (
    .op    (ir.op),
    .flags (bus.FlagsIn),
    .taken (taken)
  );

  always_ff @(posedge Clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (Reset) state_q <= ST_FETCH;
    else       state_q <= state_d;
  end

  always_ff @(posedge Clock) begin
    if (Reset)       ir_q <= '0;
    else if (accept) ir_q <= bus.instr_data;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH:     if (accept) state_d = ST_DECODE;
      ST_DECODE: begin
        if (op_alu || op_branch) state_d = ST_EXECUTE;
        else if (op_halt)        state_d = ST_HALTED;
        else                     state_d = ST_FETCH;
      end
      ST_EXECUTE:   state_d = op_alu ? ST_WRITEBACK : ST_FETCH;
      ST_WRITEBACK: state_d = ST_FETCH;
      ST_HALTED:    state_d = ST_HALTED;
      default:      state_d = ST_FETCH;
    endcase
  end

  // Outputs are forced low during Reset so an aborted instruction never
  // leaks a WF, rf_we or pc_load strobe.
  always_comb begin
    instr_ready_c = 1'b0;
    funsel_c      = '0;
    wf_c          = 1'b0;
    rsel_a_c      = '0;
    rsel_b_c      = '0;
    rf_we_c       = 1'b0;
    wsel_c        = '0;
    pc_load_c     = 1'b0;
    pc_offset_c   = '0;
    halted_c      = 1'b0;
    illegal_c     = 1'b0;
    if (!Reset) begin
      case (state_q)
        ST_FETCH: instr_ready_c = 1'b1;
        ST_DECODE: begin
          if (op_alu) begin
            funsel_c = ir.op[4:0];
            rsel_a_c = ir.src1;
            rsel_b_c = ir.src2;
          end else if (!op_branch && !op_halt) begin
            illegal_c = 1'b1;
          end
        end
        ST_EXECUTE: begin
          if (op_alu) begin
            funsel_c = ir.op[4:0];
            rsel_a_c = ir.src1;
            rsel_b_c = ir.src2;
            wf_c     = ir.s;
          end else if (taken) begin
            pc_load_c   = 1'b1;
            pc_offset_c = offset_sext;
          end
        end
        ST_WRITEBACK: begin
          funsel_c = ir.op[4:0];
          rsel_a_c = ir.src1;
          rsel_b_c = ir.src2;
          rf_we_c  = 1'b1;
          wsel_c   = ir.dst;
        end
        ST_HALTED: halted_c = 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.instr_ready = instr_ready_c;
  assign bus.FunSel      = funsel_c;
  assign bus.WF          = wf_c;
  assign bus.rf_rsel_a   = rsel_a_c;
  assign bus.rf_rsel_b   = rsel_b_c;
  assign bus.rf_we       = rf_we_c;
  assign bus.rf_wsel     = wsel_c;
  assign bus.pc_load     = pc_load_c;
  assign bus.pc_offset   = pc_offset_c;
  assign bus.halted      = halted_c;
  assign bus.illegal_op  = illegal_c;

endmodule

// File: tb/tb_alu_control_sequencer.sv
// Directed bench for alu_control_sequencer: ALU sequence, branches, illegal,
// halt, reset abort and back-to-back issue against hand-computed outputs.
module tb_alu_control_sequencer;

  typedef struct packed {
    logic        ready;
    logic [4:0]  funsel;
    logic        wf;
    logic [2:0]  rsel_a;
    logic [2:0]  rsel_b;
    logic        rf_we;
    logic [2:0]  wsel;
    logic        pc_load;
    logic [15:0] pc_offset;
    logic        halted;
    logic        illegal;
  } out_t;

  typedef struct packed {
    logic [15:0] instr;
    logic [3:0]  flags;
    logic        taken;
    logic [15:0] off;
  } br_vec_t;

  logic Clock;
  logic Reset;
  int   checks;
  int   errors;

  alu_control_sequencer_if #(.INSTR_W(16), .PC_W(16)) bus ();

  alu_control_sequencer dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  function automatic out_t snap();
    out_t o;
    o.ready     = bus.instr_ready;
    o.funsel    = bus.FunSel;
    o.wf        = bus.WF;
    o.rsel_a    = bus.rf_rsel_a;
    o.rsel_b    = bus.rf_rsel_b;
    o.rf_we     = bus.rf_we;
    o.wsel      = bus.rf_wsel;
    o.pc_load   = bus.pc_load;
    o.pc_offset = bus.pc_offset;
    o.halted    = bus.halted;
    o.illegal   = bus.illegal_op;
    return o;
  endfunction

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Presents one word and returns #1 after the accepting edge (DECODE cycle).
  task automatic send(input logic [15:0] w);
    int n = 0;
    bus.instr_valid = 1'b1;
    bus.instr_data  = w;
    while (!bus.instr_ready && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 20) begin
      errors++;
      $display("FAIL send_timeout: instr_ready stayed %b, required 1 (word %h)", bus.instr_ready, w);
    end
    tick();
    bus.instr_valid = 1'b0;
  endtask

  task automatic test_reset();
    out_t exp;
    Reset = 1'b1;
    bus.instr_valid = 1'b0;
    bus.instr_data  = '0;
    bus.FlagsIn     = '0;
    tick();
    tick();
    exp = '0;
    checks++;
    if (snap() !== exp) begin
      errors++;
      $display("FAIL reset_held: got %h required %h", snap(), exp);
    end
    Reset = 1'b0;
    #1;
    exp.ready = 1'b1;
    checks++;
    if (snap() !== exp) begin
      errors++;
      $display("FAIL reset_release: got %h required %h", snap(), exp);
    end
  endtask

  task automatic test_alu_add();
    out_t exp;
    send(16'h5253);
    exp = '0;
    exp.funsel = 5'b10100;
    exp.rsel_a = 3'd2;
    exp.rsel_b = 3'd3;
    checks++;
    if (snap() !== exp) begin
      errors++;
      $display("FAIL add_decode: got %h required %h", snap(), exp);
    end
    tick();
    exp.wf = 1'b1;
    checks++;
    if (snap() !== exp) begin
      errors++;
      $display("FAIL add_execute: got %h required %h", snap(), exp);
    end
    tick();
    exp.wf    = 1'b0;
    exp.rf_we = 1'b1;
    exp.wsel  = 3'd1;
    checks++;
    if (snap() !== exp) begin
      errors++;
      $display("FAIL add_writeback: got %h required %h", snap(), exp);
    end
    tick();
    exp = '0;
    exp.ready = 1'b1;
    checks++;
    if (snap() !== exp) begin
      errors++;
      $display("FAIL add_refetch: got %h required %h", snap(), exp);
    end
  endtask

  task automatic test_branches();
    br_vec_t vecs [10] = '{
      '{16'h87FC, 4'b1000, 1'b1, 16'hFFFC},
      '{16'h87FC, 4'b0000, 1'b0, 16'h0000},
      '{16'h8005, 4'b0000, 1'b1, 16'h0005},
      '{16'h8805, 4'b1000, 1'b0, 16'h0000},
      '{16'h8B01, 4'b0111, 1'b1, 16'hFF01},
      '{16'h8CFF, 4'b0100, 1'b1, 16'h00FF},
      '{16'h8CFF, 4'b1011, 1'b0, 16'h0000},
      '{16'h9010, 4'b0010, 1'b1, 16'h0010},
      '{16'h9410, 4'b0001, 1'b1, 16'h0010},
      '{16'h9410, 4'b1110, 1'b0, 16'h0000}
    };
    out_t exp;
    for (int i = 0; i < 10; i++) begin
      bus.FlagsIn = vecs[i].flags;
      send(vecs[i].instr);
      exp = '0;
      checks++;
      if (snap() !== exp) begin
        errors++;
        $display("FAIL branch_decode[%0d]: got %h required %h", i, snap(), exp);
      end
      tick();
      exp.pc_load   = vecs[i].taken;
      exp.pc_offset = vecs[i].off;
      checks++;
      if (snap() !== exp) begin
        errors++;
        $display("FAIL branch_execute[%0d]: got %h required %h", i, snap(), exp);
      end
      tick();
      exp = '0;
      exp.ready = 1'b1;
      checks++;
      if (snap() !== exp) begin
        errors++;
        $display("FAIL branch_refetch[%0d]: got %h required %h", i, snap(), exp);
      end
    end
    bus.FlagsIn = '0;
  endtask

  task automatic test_illegal();
    logic [15:0] words [2] = '{16'h9800, 16'hA3C0};
    out_t exp;
    for (int i = 0; i < 2; i++) begin
      send(words[i]);
      exp = '0;
      exp.illegal = 1'b1;
      checks++;
      if (snap() !== exp) begin
        errors++;
        $display("FAIL illegal_decode[%0d]: got %h required %h", i, snap(), exp);
      end
      tick();
      exp = '0;
      exp.ready = 1'b1;
      checks++;
      if (snap() !== exp) begin
        errors++;
        $display("FAIL illegal_refetch[%0d]: got %h required %h", i, snap(), exp);
      end
    end
  endtask

  task automatic test_halt();
    out_t exp;
    send(16'hFC00);
    exp = '0;
    checks++;
    if (snap() !== exp) begin
      errors++;
      $display("FAIL halt_decode: got %h required %h", snap(), exp);
    end
    bus.instr_valid = 1'b1;
    bus.instr_data  = 16'h5253;
    exp.halted = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (snap() !== exp) begin
        errors++;
        $display("FAIL halt_hold[%0d]: got %h required %h", i, snap(), exp);
      end
    end
    Reset = 1'b1;
    tick();
    bus.instr_valid = 1'b0;
    Reset = 1'b0;
    #1;
    exp = '0;
    exp.ready = 1'b1;
    checks++;
    if (snap() !== exp) begin
      errors++;
      $display("FAIL halt_reset_exit: got %h required %h", snap(), exp);
    end
  endtask

  task automatic test_reset_mid();
    out_t exp;
    int   strobes = 0;
    send(16'h5253);
    tick();
    Reset = 1'b1;
    tick();
    exp = '0;
    checks++;
    if (snap() !== exp) begin
      errors++;
      $display("FAIL reset_mid_abort: got %h required %h", snap(), exp);
    end
    Reset = 1'b0;
    #1;
    exp.ready = 1'b1;
    checks++;
    if (snap() !== exp) begin
      errors++;
      $display("FAIL reset_mid_refetch: got %h required %h", snap(), exp);
    end
    for (int i = 0; i < 6; i++) begin
      if (bus.rf_we || bus.WF || bus.pc_load) strobes++;
      tick();
    end
    checks++;
    if (strobes !== 0) begin
      errors++;
      $display("FAIL reset_mid_strobes: got %0d strobe cycles required 0", strobes);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] ops [8];
    int   k = 0;
    int   w = 0;
    int   last = -1;
    out_t o;
    for (int i = 0; i < 8; i++) ops[i] = {6'(i + 3), 1'b0, 3'(i), 3'(7 - i), 3'(i)};
    bus.instr_valid = 1'b1;
    bus.instr_data  = ops[0];
    for (int c = 0; c < 60 && w < 8; c++) begin
      o = snap();
      if (o.rf_we) begin
        checks++;
        if (o.wsel !== 3'(w) || o.funsel !== 5'(w + 3) || o.rsel_a !== 3'(7 - w)) begin
          errors++;
          $display("FAIL b2b_writeback[%0d]: got wsel %0d funsel %0d rsel_a %0d required %0d %0d %0d",
                   w, o.wsel, o.funsel, o.rsel_a, w, w + 3, 7 - w);
        end
        w++;
      end
      if (o.ready && k < 8) begin
        if (last >= 0) begin
          checks++;
          if (c - last !== 4) begin
            errors++;
            $display("FAIL b2b_spacing[%0d]: got %0d cycles required 4", k, c - last);
          end
        end
        last = c;
        k++;
      end
      tick();
      if (k < 8) bus.instr_data = ops[k];
      else       bus.instr_valid = 1'b0;
    end
    bus.instr_valid = 1'b0;
    checks++;
    if (k !== 8 || w !== 8) begin
      errors++;
      $display("FAIL b2b_count: got %0d accepts %0d writebacks required 8 8", k, w);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_alu_add();
    test_branches();
    test_illegal();
    test_halt();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
